// File: rtl/led_pattern_scheduler_if.sv
// Control/status bundle between front-end inputs and the LED
// pattern scheduler: mode/encoder inputs in, pattern index out.
interface led_pattern_scheduler_if;
  logic       en;
  logic [1:0] mode;
  logic [4:0] enc_in;
  logic       enc_valid;
  logic       pause;
  logic [4:0] idx_out;
  logic       idx_strobe;
  logic       busy;

  modport master (
    output en,
    output mode,
    output enc_in,
    output enc_valid,
    output pause,
    input  idx_out,
    input  idx_strobe,
    input  busy
  );

  modport slave (
    input  en,
    input  mode,
    input  enc_in,
    input  enc_valid,
    input  pause,
    output idx_out,
    output idx_strobe,
    output busy
  );
endinterface

// File: rtl/led_pattern_scheduler.sv
// LED pattern index scheduler: manual, auto-run, bounce and hold modes.
// Optional manual inactivity blanking under LED_SCHED_TIMEOUT_EN.
module led_pattern_scheduler #(
  parameter int TICK_DIV   = 100_000,
  parameter int STEP_TICKS = 250,
  parameter int IDX_MAX    = 14
`ifdef LED_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 2000
`endif
) (
  input logic                     clk,
  input logic                     rst_n,
  led_pattern_scheduler_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [4:0]    IMAX     = 5'(IDX_MAX);
  localparam logic [4:0]    IDX_OFF  = 5'h1F;

  typedef enum logic [2:0] {
    S_OFF,
    S_MANUAL,
    S_RUN,
    S_BOUNCE,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_stc;
  logic [SW-1:0] w_stc_nxt;
  logic [4:0]    r_idx;
  logic [4:0]    w_idx_nxt;
  logic          r_dir_up;
  logic          w_dir_nxt;
  logic          r_strobe;
  logic          r_busy;
  logic          w_tick;
  logic          w_chg;
  logic          w_auto;
  logic          w_nauto;
  logic          w_step;
  logic          w_go_up;
  logic [4:0]    w_enc_clip;

`ifdef LED_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] INA_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] r_ina;
  logic [TW-1:0] w_ina_nxt;
  logic          r_tout;
  logic          w_tout_nxt;
  logic          w_tout_hit;
`endif

  always_comb begin
    w_nstate = S_OFF;
    if (bus.en) begin
      unique case (bus.mode)
        2'b00:   w_nstate = S_MANUAL;
        2'b01:   w_nstate = S_RUN;
        2'b10:   w_nstate = S_BOUNCE;
        default: w_nstate = S_HOLD;
      endcase
    end
  end

  assign w_chg   = (w_nstate != r_state);
  assign w_auto  = (r_state == S_RUN) || (r_state == S_BOUNCE);
  assign w_nauto = (w_nstate == S_RUN) || (w_nstate == S_BOUNCE);
  assign w_tick  = (r_pre == PRE_LAST);
  assign w_step  = w_auto && !w_chg && !bus.pause
                && w_tick && (r_stc == STP_LAST);

  // Go up from 0, or while flagged up and below the top.
  assign w_go_up = (r_idx == 5'd0) || (r_dir_up && (r_idx < IMAX));

  assign w_enc_clip = (bus.enc_in > IMAX) ? IMAX : bus.enc_in;

  always_comb begin
    w_stc_nxt = r_stc;
    if (w_chg) begin
      w_stc_nxt = '0;
    end else if (w_auto && !bus.pause && w_tick) begin
      w_stc_nxt = (r_stc == STP_LAST) ? '0 : r_stc + 1'b1;
    end
  end

`ifdef LED_SCHED_TIMEOUT_EN
  assign w_tout_hit = (r_state == S_MANUAL) && !w_chg
                   && !bus.enc_valid && w_tick
                   && !r_tout && (r_ina == INA_LAST);

  always_comb begin
    w_ina_nxt  = r_ina;
    w_tout_nxt = r_tout;
    if (w_chg || ((r_state == S_MANUAL) && bus.enc_valid)) begin
      w_ina_nxt  = '0;
      w_tout_nxt = 1'b0;
    end else if (w_tout_hit) begin
      w_ina_nxt  = '0;
      w_tout_nxt = 1'b1;
    end else if ((r_state == S_MANUAL) && w_tick && !r_tout) begin
      w_ina_nxt  = r_ina + 1'b1;
    end
  end
`endif

  always_comb begin
    w_idx_nxt = r_idx;
    w_dir_nxt = r_dir_up;
    if (w_nstate == S_OFF) begin
      w_idx_nxt = IDX_OFF;
      w_dir_nxt = 1'b1;
    end else if (w_chg) begin
      w_dir_nxt = 1'b1;
      if (w_nauto && ((r_state == S_OFF) || (r_idx > IMAX))) begin
        w_idx_nxt = 5'd0;
      end
    end else if (w_step) begin
      if (r_state == S_RUN) begin
        w_idx_nxt = (r_idx >= IMAX) ? 5'd0 : r_idx + 5'd1;
      end else if (w_go_up) begin
        w_idx_nxt = r_idx + 5'd1;
        w_dir_nxt = (r_idx + 5'd1) != IMAX;
      end else begin
        w_idx_nxt = r_idx - 5'd1;
        w_dir_nxt = (r_idx - 5'd1) == 5'd0;
      end
    end else if ((r_state == S_MANUAL) && bus.enc_valid) begin
      w_idx_nxt = w_enc_clip;
`ifdef LED_SCHED_TIMEOUT_EN
    end else if (w_tout_hit) begin
      w_idx_nxt = IDX_OFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_OFF;
      r_pre    <= '0;
      r_stc    <= '0;
      r_idx    <= IDX_OFF;
      r_dir_up <= 1'b1;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      r_stc    <= w_stc_nxt;
      r_idx    <= w_idx_nxt;
      r_dir_up <= w_dir_nxt;
      r_strobe <= (w_idx_nxt != r_idx);
      r_busy   <= w_nauto && !bus.pause;
    end
  end

`ifdef LED_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ina  <= '0;
      r_tout <= 1'b0;
    end else begin
      r_ina  <= w_ina_nxt;
      r_tout <= w_tout_nxt;
    end
  end
`endif

  assign bus.idx_out    = r_idx;
  assign bus.idx_strobe = r_strobe;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench for led_pattern_scheduler (TICK_DIV=4, STEP_TICKS=2).
// Expected indices are queued by stimulus and popped on each strobe.
module tb_led_pattern_scheduler;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   last_cyc;
  int   c0;
  logic [4:0] q[$];

  led_pattern_scheduler_if u_if();

  led_pattern_scheduler #(
    .TICK_DIV   (4),
    .STEP_TICKS (2),
    .IDX_MAX    (14)
`ifdef LED_SCHED_TIMEOUT_EN
    , .TIMEOUT_TICKS (5)
`endif
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest queued expectation.
  initial begin
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (u_if.idx_strobe) begin
        last_cyc = cyc;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexp: idx_out=%0d, required no strobe",
                   u_if.idx_out);
        end else begin
          logic [4:0] e;
          e = q.pop_front();
          if (u_if.idx_out != e) begin
            n_fail++;
            $display("FAIL strobe_idx: idx_out=%0d, required %0d",
                     u_if.idx_out, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d strobes still pending, required 0",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic enc(input logic [4:0] v);
    u_if.enc_in    = v;
    u_if.enc_valid = 1'b1;
    step();
    u_if.enc_valid = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    u_if.en        = 1'b0;
    u_if.mode      = 2'b00;
    u_if.enc_in    = 5'd0;
    u_if.enc_valid = 1'b0;
    u_if.pause     = 1'b0;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_idx", u_if.idx_out, 31);
    check("rst_strobe", u_if.idx_strobe, 0);
    check("rst_busy", u_if.busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Manual: forward, clamp, no strobe on repeat
    u_if.en = 1'b1;
    repeat (3) step();
    check("man_idle", u_if.idx_out, 31);
    q.push_back(5'd7);
    enc(5'd7);
    drain("man_7", 4);
    q.push_back(5'd14);
    enc(5'd20);
    drain("man_clamp", 4);
    enc(5'd14);
    repeat (3) step();
    check("man_same", u_if.idx_out, 14);

    // Auto-run from OFF
    u_if.en = 1'b0;
    q.push_back(5'd31);
    drain("off_1", 4);
    u_if.en   = 1'b1;
    u_if.mode = 2'b01;
    q.push_back(5'd0);
    for (int i = 1; i <= 14; i++) q.push_back(5'(i));
    q.push_back(5'd0);
    repeat (12) step();
    check("run_busy", u_if.busy, 1);
    drain("run_wrap", 16 * 8 + 16);

    // Bounce from OFF
    u_if.en = 1'b0;
    q.push_back(5'd31);
    drain("off_2", 4);
    u_if.en   = 1'b1;
    u_if.mode = 2'b10;
    q.push_back(5'd0);
    for (int i = 1; i <= 14; i++) q.push_back(5'(i));
    for (int i = 13; i >= 0; i--) q.push_back(5'(i));
    q.push_back(5'd1);
    drain("bounce", 30 * 8 + 16);
    check("bounce_busy", u_if.busy, 1);

    // Bounce -> run continues from 1, then pause at 5
    u_if.mode = 2'b01;
    for (int i = 2; i <= 5; i++) q.push_back(5'(i));
    drain("run_to5", 5 * 8 + 8);
    u_if.pause = 1'b1;
    repeat (40) step();
    check("pause_idx", u_if.idx_out, 5);
    check("pause_busy", u_if.busy, 0);
    c0 = cyc;
    u_if.pause = 1'b0;
    q.push_back(5'd6);
    drain("resume", 16);
    n_tests++;
    if ((last_cyc - c0) < 4 || (last_cyc - c0) > 9) begin
      n_fail++;
      $display("FAIL resume_lat: got %0d cycles, required 4..9",
               last_cyc - c0);
    end

    // en drop at idx 9
    for (int i = 7; i <= 9; i++) q.push_back(5'(i));
    drain("run_to9", 4 * 8);
    u_if.en = 1'b0;
    q.push_back(5'd31);
    drain("en_drop", 3);
    check("off_busy", u_if.busy, 0);

    // Hold freezes, then bounce continues from current index
    u_if.en   = 1'b1;
    u_if.mode = 2'b01;
    q.push_back(5'd0);
    q.push_back(5'd1);
    drain("run_to1", 24);
    u_if.mode = 2'b11;
    repeat (30) step();
    check("hold_idx", u_if.idx_out, 1);
    check("hold_busy", u_if.busy, 0);
    u_if.mode = 2'b10;
    q.push_back(5'd2);
    q.push_back(5'd3);
    drain("hold_bounce", 3 * 8);

    // Asynchronous reset mid-bounce
    #3 rst_n = 1'b0;
    #1;
    check("arst_idx", u_if.idx_out, 31);
    check("arst_strobe", u_if.idx_strobe, 0);
    check("arst_busy", u_if.busy, 0);
    u_if.en = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("post_rst_idx", u_if.idx_out, 31);

`ifdef LED_SCHED_TIMEOUT_EN
    u_if.en   = 1'b1;
    u_if.mode = 2'b00;
    repeat (2) step();
    q.push_back(5'd3);
    enc(5'd3);
    drain("tout_3", 4);
    q.push_back(5'd31);
    drain("tout_blank", 5 * 4 + 12);
    q.push_back(5'd4);
    enc(5'd4);
    drain("tout_4", 4);
`endif

    repeat (5) step();
    check("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
